input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 131 +++++++++++++
 tb/tb_input_debouncer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// ============================================================================
//  Module   : input_debouncer
//  Brief    : Two-stage synchronizer plus four-state qualifier that turns a
//             bouncing level into a clean registered level with edge pulses.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module input_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic D,
  output logic Q,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam int              c_CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(STABLE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0] c_CNT_ZERO = '0;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic            r_s1;
  logic            r_s2;
  logic            r_q;
  logic            r_rise;
  logic            r_fall;
  logic            w_q_nxt;
  logic            w_rise_nxt;
  logic            w_fall_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= c_CNT_ZERO;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= D;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // cnt counts qualifying samples already seen; the sample that reaches
  // STABLE_CYCLES completes the change instead of incrementing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (r_s2) begin
          w_state_nxt = PEND_HI;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_cnt_nxt   = c_CNT_ZERO;
        end
      end
      PEND_HI: begin
        if (!r_s2) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = c_CNT_ZERO;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = c_CNT_ZERO;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = PEND_LO;
          w_cnt_nxt   = c_CNT_ONE;
        end else begin
          w_cnt_nxt   = c_CNT_ZERO;
        end
      end
      PEND_LO: begin
        if (r_s2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = c_CNT_ZERO;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = c_CNT_ZERO;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = c_CNT_ZERO;
      end
    endcase
  end

  assign Q       = r_q;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign pending = (r_state == PEND_HI) || (r_state == PEND_LO);

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
//  Module   : tb_input_debouncer
//  Brief    : Self-checking bench: directed vector table, toggle sequence and
//             random bursts compared against a sample-window reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_input_debouncer;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic D;
  logic Q;
  logic rise;
  logic fall;
  logic pending;

  int n_checks = 0;
  int n_pass   = 0;

  input_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .D       (D),
    .Q       (Q),
    .rise    (rise),
    .fall    (fall),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: Q flips once the last N samples seen by the qualifier
  // (D delayed by two synchronizer stages) all differ from Q.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_pend = 1'b0;
  bit   hist[$];

  always @(posedge clk) begin
    int run;
    bit all_diff;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > N) void'(hist.pop_front());
      m_rise = 1'b0;
      m_fall = 1'b0;
      all_diff = (hist.size() == N);
      foreach (hist[i]) if (hist[i] == m_q) all_diff = 1'b0;
      if (all_diff) begin
        m_q    = ~m_q;
        m_rise = m_q;
        m_fall = ~m_q;
      end
      m_s2 = m_s1;
      m_s1 = D;
    end
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == m_q) break;
      run++;
    end
    m_pend = (run > 0);
  end

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic r;
    logic d;
    logic q;
    logic ri;
    logic fa;
    logic pe;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    D   = 1'b0;
    // {rst, D, Q, rise, fall, pending} after each edge
    // reset, then qualified rise
    tbl.push_back(6'b10_0000); tbl.push_back(6'b10_0000);
    tbl.push_back(6'b01_0000); tbl.push_back(6'b01_0000);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b01_0001);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b01_1100);
    tbl.push_back(6'b01_1000); tbl.push_back(6'b01_1000);
    // qualified fall
    tbl.push_back(6'b00_1000); tbl.push_back(6'b00_1000);
    tbl.push_back(6'b00_1001); tbl.push_back(6'b00_1001);
    tbl.push_back(6'b00_1001); tbl.push_back(6'b00_0010);
    tbl.push_back(6'b00_0000);
    // three-cycle glitch rejected
    tbl.push_back(6'b01_0000); tbl.push_back(6'b01_0000);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b00_0001);
    tbl.push_back(6'b00_0001); tbl.push_back(6'b00_0000);
    tbl.push_back(6'b00_0000);
    // reset on the completing edge, then D=1 through reset release
    tbl.push_back(6'b01_0000); tbl.push_back(6'b01_0000);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b01_0001);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b11_0000);
    tbl.push_back(6'b01_0000); tbl.push_back(6'b01_0000);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b01_0001);
    tbl.push_back(6'b01_0001); tbl.push_back(6'b01_1100);
    tbl.push_back(6'b01_1000);

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      D   = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_Q", i),       Q,       tbl[i].q);
      chk($sformatf("vec%0d_rise", i),    rise,    tbl[i].ri);
      chk($sformatf("vec%0d_fall", i),    fall,    tbl[i].fa);
      chk($sformatf("vec%0d_pending", i), pending, tbl[i].pe);
    end

    // D toggling every cycle never qualifies
    rst = 1'b1; D = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      D = ~D;
      chk($sformatf("toggle%0d_Q", i),    Q,    1'b0);
      chk($sformatf("toggle%0d_rise", i), rise, 1'b0);
      chk($sformatf("toggle%0d_fall", i), fall, 1'b0);
    end

    // random bursts of 1..7 cycles with occasional reset
    begin
      int cyc;
      int hold;
      cyc = 0;
      while (cyc < 2000) begin
        D    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
        for (int h = 0; h < hold; h++) begin
          rst = ($urandom_range(0, 63) == 0);
          @(posedge clk); #1;
          chk("rand_Q",       Q,       m_q);
          chk("rand_rise",    rise,    m_rise);
          chk("rand_fall",    fall,    m_fall);
          chk("rand_pending", pending, m_pend);
          chk("rand_excl",    rise & fall, 1'b0);
          cyc++;
        end
      end
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
